// File: rtl/scytale_encryption_pkg.sv
// Shared definitions for the scytale encryption/decryption pair.
// Holds the default data/key widths, the end-of-message token that both
// sides agree on, and the encryption FSM state encoding.
package scytale_encryption_pkg;

    localparam int         SCY_D_WIDTH     = 8;
    localparam int         SCY_KEY_WIDTH   = 8;
    localparam logic [7:0] SCY_START_TOKEN = 8'hFA;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/scytale_addr_gen.sv
// Read-address generator for scytale encryption.
// Latches N/M and the N*M output count when a message is started, then walks
// the buffer column-major (idx += N down a column, idx = c at a column wrap)
// without a multiplier in the address path.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - token accepted: latch keys and clear the walk
//   step          - one byte emitted this cycle: advance the walk
//   key_N, key_M  - columns / rows, sampled on start
//   idx           - buffer index of the byte to emit next (saturates at MAX)
//   done          - every one of the N*M bytes has been emitted
module scytale_addr_gen
    import scytale_encryption_pkg::*;
#(
    parameter int KEY_WIDTH     = SCY_KEY_WIDTH,
    parameter int MAX_NOF_CHARS = 50,
    parameter int CW            = $clog2(MAX_NOF_CHARS) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [CW-1:0]        idx,
    output logic                 done
);

    // Sum width wide enough that idx + N or c + 1 can never wrap.
    localparam int SW = ((CW > KEY_WIDTH) ? CW : KEY_WIDTH) + 1;

    logic [KEY_WIDTH-1:0]   n_lat;
    logic [KEY_WIDTH-1:0]   m_lat;
    logic [KEY_WIDTH-1:0]   row;
    logic [KEY_WIDTH-1:0]   col;
    logic [2*KEY_WIDTH-1:0] total;
    logic [2*KEY_WIDTH-1:0] cnt;

    // Clamp to MAX so an out-of-range position stays out of range; with a
    // plain truncation a large N could wrap idx back into the buffer.
    function automatic logic [CW-1:0] sat_idx(input logic [SW-1:0] v);
        if (v >= SW'(MAX_NOF_CHARS))
            return CW'(MAX_NOF_CHARS);
        return v[CW-1:0];
    endfunction

    assign done = (cnt == total);

    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat <= '0;
            m_lat <= '0;
            row   <= '0;
            col   <= '0;
            total <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (start) begin
            n_lat <= key_N;
            m_lat <= key_M;
            total <= (2*KEY_WIDTH)'(key_N) * (2*KEY_WIDTH)'(key_M);
            row   <= '0;
            col   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            // step only happens while cnt < N*M, so M >= 1 here
            if (row == m_lat - 1'b1) begin
                row <= '0;
                col <= col + 1'b1;
                idx <= sat_idx(SW'(col) + SW'(1));
            end else begin
                row <= row + 1'b1;
                idx <= sat_idx(SW'(idx) + SW'(n_lat));
            end
        end
    end

endmodule

// File: rtl/scytale_encryption.sv
// Scytale encryption engine.
// Buffers plaintext bytes until the start token arrives, then emits the
// column-major reading of the key_M x key_N row-major grid, one byte per clock.
// Positions beyond the received message (or the buffer) are sent as 8'h00.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   data_i        - plaintext byte, qualified by valid_i
//   valid_i       - input qualifier (ignored while busy)
//   key_N, key_M  - columns / rows, latched with the token
//   data_o        - ciphertext byte, registered, zero when valid_o is low
//   valid_o       - output qualifier, registered
//   busy          - high while emitting
module scytale_encryption
    import scytale_encryption_pkg::*;
#(
    parameter int                 D_WIDTH                = SCY_D_WIDTH,
    parameter int                 KEY_WIDTH              = SCY_KEY_WIDTH,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = D_WIDTH'(SCY_START_TOKEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);

    localparam int CW = $clog2(MAX_NOF_CHARS) + 1;
    localparam int AW = $clog2(MAX_NOF_CHARS);

    state_t               state;
    logic [CW-1:0]        wr_cnt;
    logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];
    logic [CW-1:0]        idx;
    logic                 done;
    logic                 is_token;
    logic                 accept_tok;
    logic                 accept_byte;
    logic                 step;
    logic [D_WIDTH-1:0]   rd_byte;

    assign is_token    = (data_i == START_ENCRYPTION_TOKEN);
    assign accept_tok  = (state == COLLECT) && valid_i && is_token;
    assign accept_byte = (state == COLLECT) && valid_i && !is_token
                         && (wr_cnt < CW'(MAX_NOF_CHARS));
    assign step        = (state == EMIT) && !done;

    // Unwritten positions of a short message read as zero.
    assign rd_byte = ((idx < wr_cnt) && (idx < CW'(MAX_NOF_CHARS)))
                     ? mem[idx[AW-1:0]] : '0;

    scytale_addr_gen #(
        .KEY_WIDTH     (KEY_WIDTH),
        .MAX_NOF_CHARS (MAX_NOF_CHARS),
        .CW            (CW)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .start (accept_tok),
        .step  (step),
        .key_N (key_N),
        .key_M (key_M),
        .idx   (idx),
        .done  (done)
    );

    // Message buffer: contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!rst && accept_byte)
            mem[wr_cnt[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            wr_cnt  <= '0;
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    valid_o <= 1'b0;
                    data_o  <= '0;
                    if (accept_tok) begin
                        state <= EMIT;
                        busy  <= 1'b1;
                    end else if (accept_byte) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (done) begin
                        state   <= COLLECT;
                        busy    <= 1'b0;
                        valid_o <= 1'b0;
                        data_o  <= '0;
                        wr_cnt  <= '0;
                    end else begin
                        valid_o <= 1'b1;
                        data_o  <= rd_byte;
                    end
                end
                default: begin
                    state   <= COLLECT;
                    busy    <= 1'b0;
                    valid_o <= 1'b0;
                    data_o  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scytale_encryption.sv
// Self-checking bench for scytale_encryption: a vector table of
// {keys, message, expected ciphertext} plus hand-written sequences for
// overflow, busy blocking, and reset during emission.
module tb_scytale_encryption;
    import scytale_encryption_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N;
    logic [7:0] key_M;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy;

    always #5 clk = ~clk;

    scytale_encryption dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key_N   (key_N),
        .key_M   (key_M),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy    (busy)
    );

    typedef struct {
        int          n;
        int          m;
        int          len;
        logic [63:0] msg;
        int          elen;
        logic [63:0] exp;
        string       name;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [7:0] msg_b [64];
    logic [7:0] exp_b [64];
    logic [7:0] got_b [64];
    int msg_n, exp_n, got_n, busy_cyc, first_v, last_v, zero_viol, gap_viol;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends msg_b[0..msg_n-1] and the token, then records the emission.
    task automatic run(input int n, input int m, input bit jam);
        logic [7:0] js [4];
        js[0] = "X"; js[1] = "Y"; js[2] = "Z"; js[3] = SCY_START_TOKEN;
        key_N = 8'(n);
        key_M = 8'(m);
        for (int i = 0; i < msg_n; i++) begin
            valid_i = 1'b1;
            data_i  = msg_b[i];
            tick();
        end
        valid_i = 1'b1;
        data_i  = SCY_START_TOKEN;
        tick();
        valid_i = 1'b0;
        data_i  = 8'h00;
        got_n = 0; busy_cyc = 0; first_v = -1; last_v = -1;
        zero_viol = 0; gap_viol = 0;
        if (busy) busy_cyc = 1;
        if (valid_o) first_v = 0;
        for (int cyc = 1; cyc < 200 && busy; cyc++) begin
            if (jam) begin
                valid_i = 1'b1;
                data_i  = js[cyc % 4];
                key_N   = 8'd7;
                key_M   = 8'd9;
            end
            tick();
            if (valid_o) begin
                if (first_v < 0) first_v = cyc;
                else if (cyc != last_v + 1) gap_viol++;
                last_v = cyc;
                if (got_n < 64) got_b[got_n] = data_o;
                got_n++;
            end else if (data_o != 8'h00) begin
                zero_viol++;
            end
            if (busy) busy_cyc++;
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic check(input string nm);
        chk({nm, "_busy_end"}, 32'(busy), 32'd0);
        chk({nm, "_busy_cycles"}, busy_cyc, exp_n + 1);
        chk({nm, "_count"}, got_n, exp_n);
        if (exp_n > 0) chk({nm, "_first_valid_cycle"}, first_v, 1);
        chk({nm, "_idle_data_nonzero"}, zero_viol, 0);
        chk({nm, "_valid_gap"}, gap_viol, 0);
        for (int i = 0; i < exp_n && i < got_n && i < 64; i++)
            chk($sformatf("%s_byte%0d", nm, i), 32'(got_b[i]), 32'(exp_b[i]));
    endtask

    task automatic load(input vec_t v);
        msg_n = v.len;
        exp_n = v.elen;
        for (int i = 0; i < v.len; i++)  msg_b[i] = v.msg[8*(v.len-1-i) +: 8];
        for (int i = 0; i < v.elen; i++) exp_b[i] = v.exp[8*(v.elen-1-i) +: 8];
    endtask

    vec_t vecs [10];
    vec_t nominal;

    initial begin
        vecs[0] = '{3, 2, 6, 64'("ABCDEF"), 6, 64'("ADBECF"), "nominal"};
        vecs[1] = '{3, 2, 4, 64'("ABCD"),   6, 64'({"ADB", 8'h00, "C", 8'h00}), "short"};
        vecs[2] = '{2, 3, 6, 64'("ABCDEF"), 6, 64'("ACEBDF"), "n2m3"};
        vecs[3] = '{1, 3, 3, 64'("XYZ"),    3, 64'("XYZ"),    "n1m3"};
        vecs[4] = '{3, 1, 3, 64'("XYZ"),    3, 64'("XYZ"),    "n3m1"};
        vecs[5] = '{2, 2, 0, 64'h0,         4, 64'h0,         "empty"};
        vecs[6] = '{0, 4, 2, 64'("AB"),     0, 64'h0,         "deg_n0"};
        vecs[7] = '{3, 0, 2, 64'("AB"),     0, 64'h0,         "deg_m0"};
        vecs[8] = '{3, 2, 6, 64'("GHIJKL"), 6, 64'("GJHKIL"), "after_deg"};
        vecs[9] = '{2, 2, 6, 64'("ABCDEF"), 4, 64'("ACBD"),   "long_msg"};
        nominal = vecs[0];

        rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; key_N = 8'h00; key_M = 8'h00;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_data_o", 32'(data_o), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            load(vecs[v]);
            run(vecs[v].n, vecs[v].m, 1'b0);
            check(vecs[v].name);
        end

        // Overflow: 55 bytes into a 50-byte buffer, N=5 M=10.
        msg_n = 55;
        for (int i = 0; i < 55; i++) msg_b[i] = 8'(i + 1);
        exp_n = 50;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 10; r++)
                exp_b[c*10 + r] = 8'(r*5 + c + 1);
        run(5, 10, 1'b0);
        check("overflow");

        // Input and key activity during emission must not disturb anything.
        load(nominal);
        run(3, 2, 1'b1);
        check("busy_block");
        load(vecs[8]);
        run(3, 2, 1'b0);
        check("after_block");

        // Reset on the third output cycle of the nominal message.
        key_N = 8'd3; key_M = 8'd2;
        load(nominal);
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; data_i = msg_b[i]; tick();
        end
        valid_i = 1'b1; data_i = SCY_START_TOKEN; tick();
        valid_i = 1'b0; data_i = 8'h00;
        tick();
        tick();
        tick();
        chk("pre_rst_third_byte", 32'(data_o), 32'h42);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data_o", 32'(data_o), 32'd0);
        rst = 1'b0;
        tick();
        load(nominal);
        run(3, 2, 1'b0);
        check("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
